// File: rtl/cest_multi.sv
// ---------------------------------------------------------------------------
// cest_multi - parametrised OFDM channel estimator.
//
// Takes a preamble of NSYM = 2^LOG2_NSYM repeated symbols of NFFT = 2^LOG2_NFFT
// complex samples. For each sample it strips the known +/-1 preamble sign
// c_k and accumulates the result per subcarrier. The output is the average,
// H_k = acc_k >>> LOG2_NSYM, saturated to W bits. A noise variance estimate
// is built from the squared symbol-to-symbol differences. After the last
// sample, the block streams NFFT H words and then a single sigma2 strobe.
//
// Optional build macro:
//   CEST_ROUND_EN  - round half up before the H and sigma2 shifts
//                    (floor when the macro is undefined).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   di_re/di_im/di_vld              received samples (signed W)
//   di_rdy                          1 in IDLE/ACC; samples seen while 0 are dropped
//   H_estimated_re/im/idx/vld       per-subcarrier channel estimate stream
//   sigma2/sigma2_vld               unsigned noise variance, one-cycle strobe
//
// NFFT is assumed to be >= 2. Reads and writes of the same address are then
// never issued in the same cycle.
// ---------------------------------------------------------------------------
module cest_multi #(
    parameter int         W         = 12,
    parameter int         LOG2_NFFT = 9,
    parameter int         LOG2_NSYM = 1,
    parameter logic [6:0] LFSR_SEED = 7'h7F
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [W-1:0]         di_re,
    input  logic signed [W-1:0]         di_im,
    input  logic                        di_vld,
    output logic                        di_rdy,
    output logic signed [W-1:0]         H_estimated_re,
    output logic signed [W-1:0]         H_estimated_im,
    output logic        [LOG2_NFFT-1:0] H_estimated_idx,
    output logic                        H_estimated_vld,
    output logic        [W-1:0]         sigma2,
    output logic                        sigma2_vld
);

    localparam int NSYM = 1 << LOG2_NSYM;
    localparam int NFFT = 1 << LOG2_NFFT;
    localparam int AW   = W + LOG2_NSYM;                   // accumulator width
    localparam int NW   = 2*W + 2 + LOG2_NFFT + LOG2_NSYM; // noise acc width
    localparam int SH   = LOG2_NFFT + LOG2_NSYM + 1;       // sigma2 shift
    localparam int SW   = (LOG2_NSYM > 0) ? LOG2_NSYM : 1;
`ifdef CEST_ROUND_EN
    localparam int H_RND = (2**LOG2_NSYM) / 2;             // 0 when LOG2_NSYM=0
    localparam int S_RND = (2**SH) / 2;
`else
    localparam int H_RND = 0;
    localparam int S_RND = 0;
`endif
    localparam logic signed [AW:0] T_MAX = (AW+1)'((2**(W-1)) - 1);
    localparam logic signed [AW:0] T_MIN = (AW+1)'(-(2**(W-1)));

    typedef enum logic [1:0] {IDLE, ACC, OUT, NOISE} state_t;

    // Multiply by c_k. -(-2^(W-1)) cannot be represented and clips to max.
    function automatic logic signed [W-1:0] sign_apply(input logic signed [W-1:0] y,
                                                       input logic c);
        if (!c) return y;
        if (y == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
        return -y;
    endfunction

    function automatic logic signed [W-1:0] h_scale(input logic signed [AW-1:0] a);
        logic signed [AW:0] t;
        t = (AW+1)'(a) + (AW+1)'(H_RND);
        t = t >>> LOG2_NSYM;
        if (t > T_MAX) return T_MAX[W-1:0];
        if (t < T_MIN) return T_MIN[W-1:0];
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] s_scale(input logic [NW-1:0] n);
        logic [NW:0] t;
        t = {1'b0, n} + (NW+1)'(S_RND);
        t = t >> SH;
        if (t > (NW+1)'((2**W) - 1)) return '1;
        return t[W-1:0];
    endfunction

    state_t                 state;
    logic [LOG2_NFFT-1:0]   k, out_k, rd_addr;
    logic [SW-1:0]          s;
    logic [6:0]             lfsr, lfsr_cur;
    logic                   k_last, s_last;

    // Stage 1 holds the accepted sample while its RAM read completes.
    logic                   s1_vld, s1_first, s1_c;
    logic [LOG2_NFFT-1:0]   s1_k;
    logic signed [W-1:0]    s1_re, s1_im;

    logic [2*AW-1:0]        acc_mem  [NFFT];
    logic [2*W-1:0]         prev_mem [NFFT];
    logic [2*AW-1:0]        acc_rd;
    logic [2*W-1:0]         prev_rd;
    logic signed [AW-1:0]   acc_rd_re, acc_rd_im, acc_new_re, acc_new_im;
    logic signed [W-1:0]    prev_rd_re, prev_rd_im, cy_re, cy_im;
    logic signed [W:0]      d_re, d_im;
    logic signed [2*W+1:0]  sq_re, sq_im;
    logic [NW-1:0]          noise_acc, noise_inc;

    // Output pipeline: [1] = RAM data ready, [2] = scaled value ready.
    logic [2:1]             vld_pipe, sg_pipe;
    logic [LOG2_NFFT-1:0]   idx1, idx2;
    logic signed [W-1:0]    h2_re, h2_im;
    logic [W-1:0]           sg_val;

    assign k_last   = &k;
    assign s_last   = (s == SW'(NSYM - 1));
    // Each symbol restarts the sign sequence from the seed.
    assign lfsr_cur = (k == '0) ? LFSR_SEED : lfsr;
    assign rd_addr  = (state == OUT) ? out_k : k;

    assign acc_rd_re  = acc_rd[2*AW-1:AW];
    assign acc_rd_im  = acc_rd[AW-1:0];
    assign prev_rd_re = prev_rd[2*W-1:W];
    assign prev_rd_im = prev_rd[W-1:0];

    assign cy_re      = sign_apply(s1_re, s1_c);
    assign cy_im      = sign_apply(s1_im, s1_c);
    // Symbol 0 overwrites whatever the previous preamble left behind.
    assign acc_new_re = s1_first ? AW'(cy_re) : acc_rd_re + AW'(cy_re);
    assign acc_new_im = s1_first ? AW'(cy_im) : acc_rd_im + AW'(cy_im);

    assign d_re      = (W+1)'(s1_re) - (W+1)'(prev_rd_re);
    assign d_im      = (W+1)'(s1_im) - (W+1)'(prev_rd_im);
    assign sq_re     = (2*W+2)'(d_re) * (2*W+2)'(d_re);
    assign sq_im     = (2*W+2)'(d_im) * (2*W+2)'(d_im);
    assign noise_inc = NW'($unsigned(sq_re)) + NW'($unsigned(sq_im));

    // RAMs are not reset; stale contents are always overwritten at symbol 0.
    always_ff @(posedge clk) begin
        if (s1_vld) begin
            acc_mem[s1_k]  <= {acc_new_re, acc_new_im};
            prev_mem[s1_k] <= {s1_re, s1_im};
        end
        acc_rd  <= acc_mem[rd_addr];
        prev_rd <= prev_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            di_rdy          <= 1'b1;
            k               <= '0;
            s               <= '0;
            out_k           <= '0;
            lfsr            <= LFSR_SEED;
            s1_vld          <= 1'b0;
            s1_first        <= 1'b0;
            s1_c            <= 1'b0;
            s1_k            <= '0;
            s1_re           <= '0;
            s1_im           <= '0;
            noise_acc       <= '0;
            vld_pipe        <= '0;
            sg_pipe         <= '0;
            idx1            <= '0;
            idx2            <= '0;
            h2_re           <= '0;
            h2_im           <= '0;
            sg_val          <= '0;
            H_estimated_re  <= '0;
            H_estimated_im  <= '0;
            H_estimated_idx <= '0;
            H_estimated_vld <= 1'b0;
            sigma2          <= '0;
            sigma2_vld      <= 1'b0;
        end else begin
            s1_vld   <= 1'b0;
            vld_pipe <= {vld_pipe[1], 1'b0};
            sg_pipe  <= {sg_pipe[1], 1'b0};

            if (s1_vld && !s1_first) noise_acc <= noise_acc + noise_inc;

            case (state)
                IDLE, ACC: begin
                    if (di_vld) begin
                        s1_vld   <= 1'b1;
                        s1_re    <= di_re;
                        s1_im    <= di_im;
                        s1_k     <= k;
                        s1_first <= (s == '0);
                        s1_c     <= lfsr_cur[6];
                        lfsr     <= {lfsr_cur[5:0], lfsr_cur[6] ^ lfsr_cur[3]};
                        k        <= k + 1'b1;
                        if (state == IDLE) noise_acc <= '0;
                        if (k_last) s <= s_last ? '0 : s + 1'b1;
                        if (k_last && s_last) begin
                            state  <= OUT;
                            di_rdy <= 1'b0;
                            out_k  <= '0;
                        end else begin
                            state  <= ACC;
                        end
                    end
                end
                OUT: begin
                    vld_pipe[1] <= 1'b1;
                    idx1        <= out_k;
                    out_k       <= out_k + 1'b1;
                    if (&out_k) state <= NOISE;
                end
                NOISE: begin
                    sg_pipe[1] <= 1'b1;
                    sg_val     <= s_scale(noise_acc);
                    state      <= IDLE;
                    di_rdy     <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (vld_pipe[1]) begin
                h2_re <= h_scale(acc_rd_re);
                h2_im <= h_scale(acc_rd_im);
                idx2  <= idx1;
            end

            H_estimated_vld <= vld_pipe[2];
            if (vld_pipe[2]) begin
                H_estimated_re  <= h2_re;
                H_estimated_im  <= h2_im;
                H_estimated_idx <= idx2;
            end

            sigma2_vld <= sg_pipe[2];
            if (sg_pipe[2]) sigma2 <= sg_val;
        end
    end

endmodule

// File: tb/tb_cest_multi.sv
// ---------------------------------------------------------------------------
// tb_cest_multi - table-driven bench for cest_multi at default parameters
// (W=12, NFFT=512, NSYM=2). Each vector gives a constant sample value for each
// symbol. It also gives the hand-computed H for c_k=+1 and c_k=-1 bins, and
// the expected sigma2. The reset corner is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_cest_multi;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [11:0] di_re, di_im;
    logic               di_vld;
    logic               di_rdy;
    logic signed [11:0] H_estimated_re, H_estimated_im;
    logic [8:0]         H_estimated_idx;
    logic               H_estimated_vld;
    logic [11:0]        sigma2;
    logic               sigma2_vld;

    cest_multi dut (
        .clk(clk), .rst_n(rst_n),
        .di_re(di_re), .di_im(di_im), .di_vld(di_vld), .di_rdy(di_rdy),
        .H_estimated_re(H_estimated_re), .H_estimated_im(H_estimated_im),
        .H_estimated_idx(H_estimated_idx), .H_estimated_vld(H_estimated_vld),
        .sigma2(sigma2), .sigma2_vld(sigma2_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef CEST_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        int r0, i0, r1, i1;   // symbol 0 / symbol 1 sample value
        bit gaps;             // di_vld toggles 1/0
        bit junk;             // di_vld with data while di_rdy=0
        int hp_re, hp_im;     // expected H where c_k=+1
        int hn_re, hn_im;     // expected H where c_k=-1
        int sig;              // expected sigma2
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  last_acc;
    bit  c_tab [512];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the first nsamp preamble samples of v.
    task automatic drive(input vec_t v, input int nsamp);
        for (int n = 0; n < nsamp; n++) begin
            di_vld = 1'b1;
            di_re  = 12'((n < 512) ? v.r0 : v.r1);
            di_im  = 12'((n < 512) ? v.i0 : v.i1);
            step();
            last_acc = cyc;
            if (v.gaps) begin
                di_vld = 1'b0;
                di_re  = 12'h5A5;
                step();
            end
        end
        di_vld = 1'b0;
    endtask

    task automatic collect(input vec_t v, input string tag);
        int n_h = 0, n_sig = 0, lat = -1, last_h = -100, sig_cyc = 0, sig_v = -1;
        int e_re, e_im;
        chk({tag, "_rdy_busy"}, int'(di_rdy), 0);
        for (int t = 0; t < 600; t++) begin
            if (v.junk && t < 100) begin
                di_vld = 1'b1;
                di_re  = 12'($urandom);
                di_im  = 12'($urandom);
            end else begin
                di_vld = 1'b0;
            end
            step();
            if (H_estimated_vld) begin
                if (n_h == 0) lat = cyc - last_acc;
                e_re = (n_h < 512 && c_tab[n_h]) ? v.hn_re : v.hp_re;
                e_im = (n_h < 512 && c_tab[n_h]) ? v.hn_im : v.hp_im;
                chk({tag, "_idx"}, int'(H_estimated_idx), n_h);
                chk({tag, "_hre"}, int'(H_estimated_re), e_re);
                chk({tag, "_him"}, int'(H_estimated_im), e_im);
                n_h++;
                last_h = cyc;
            end
            if (sigma2_vld) begin
                n_sig++;
                sig_cyc = cyc;
                sig_v   = int'(sigma2);
            end
        end
        chk({tag, "_hcount"}, n_h, 512);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_sigcount"}, n_sig, 1);
        chk({tag, "_sigtime"}, sig_cyc - last_h, 1);
        chk({tag, "_sigma2"}, sig_v, v.sig);
        chk({tag, "_rdy_idle"}, int'(di_rdy), 1);
    endtask

    vec_t vt [7];

    initial begin
        bit [6:0] st;
        st = 7'h7F;
        for (int k = 0; k < 512; k++) begin
            c_tab[k] = st[6];
            st = {st[5:0], st[6] ^ st[3]};
        end

        vt[0] = '{100, -50, 100, -50, 0, 0, 100, -50, -100, 50, 0};
        vt[1] = '{40, 0, 0, 0, 0, 0, 20, 0, -20, 0, 400};
        vt[2] = '{100, -50, 100, -50, 1, 1, 100, -50, -100, 50, 0};
        vt[3] = '{-2048, 0, -2048, 0, 0, 1, -2048, 0, 2047, 0, 0};
        vt[4] = '{2047, 0, -2048, 0, 0, 0, RND ? 0 : -1, 0, 0, 0, 4095};
        vt[5] = '{3, 0, 0, 0, 0, 0, RND ? 2 : 1, 0, RND ? -1 : -2, 0, 2};
        vt[6] = '{-3, 0, 0, 0, 1, 0, RND ? -1 : -2, 0, RND ? 2 : 1, 0, 2};

        rst_n  = 1'b0;
        di_vld = 1'b0;
        di_re  = '0;
        di_im  = '0;
        repeat (3) step();
        chk("rst_rdy", int'(di_rdy), 1);
        chk("rst_hvld", int'(H_estimated_vld), 0);
        chk("rst_hre", int'(H_estimated_re), 0);
        chk("rst_sigvld", int'(sigma2_vld), 0);
        chk("rst_sigma2", int'(sigma2), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            drive(vt[i], 1024);
            collect(vt[i], $sformatf("v%0d", i));
            repeat (4) step();
        end

        // Abort a partial preamble with a distinct value. A clean run
        // afterwards must match vector 0 exactly.
        drive(vt[1], 300);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rdy", int'(di_rdy), 1);
        chk("mid_rst_hvld", int'(H_estimated_vld), 0);
        chk("mid_rst_sigma2", int'(sigma2), 0);
        #2;
        rst_n = 1'b1;
        step();
        drive(vt[0], 1024);
        collect(vt[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
